// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and types for the write-back stage
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load data lane selection, sign/zero extension and alignment check
module load_ext #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value,
    output logic            err
);
    import riscv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        value    = '0;
        err      = 1'b0;
        unique case (funct3)
            F3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                value = {{(XLEN-16){half_sel[15]}}, half_sel};
                err   = addr_lo[0];
            end
            F3_LHU: begin
                value = {{(XLEN-16){1'b0}}, half_sel};
                err   = addr_lo[0];
            end
            F3_LW: begin
                value = rdata;
                err   = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I write-back stage: result select, load completion, register-file write port
module wb_stage #(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_wen,
    input  logic [4:0]           in_rd,
    input  logic [1:0]           in_sel,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [XLEN-1:0]      in_alu_res,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_wen,
    output logic [4:0]           rf_rd,
    output logic [XLEN-1:0]      rf_rd_v,
    output logic                 retire,
    output logic                 load_err,
    output logic [INSTRET_W-1:0] instret
);
    import riscv_pkg::*;

    wb_state_t state_q, state_d;

    logic       ld_wen_q;
    logic [4:0] ld_rd_q;
    logic [2:0] ld_f3_q;
    logic [1:0] ld_addr_q;

    logic [2:0]      ext_f3;
    logic [1:0]      ext_addr;
    logic [XLEN-1:0] ext_value;
    logic            ext_err;

    logic            complete, is_load, wr_en, retire_d, wen_d, err_d, start_wait;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_val;

    // A pending load uses the latched type; otherwise the live MEM/WB fields.
    assign ext_f3   = (state_q == ST_WAIT_LD) ? ld_f3_q   : in_funct3;
    assign ext_addr = (state_q == ST_WAIT_LD) ? ld_addr_q : in_addr_lo;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3  (ext_f3),
        .addr_lo (ext_addr),
        .rdata   (mem_rdata),
        .value   (ext_value),
        .err     (ext_err)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign start_wait = (state_q == ST_IDLE) && in_valid && (in_sel == WB_LOAD) && !mem_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_wait) state_d = ST_WAIT_LD;
            ST_WAIT_LD: if (mem_rvalid) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        complete = 1'b0;
        is_load  = 1'b0;
        wr_en    = in_wen;
        wr_rd    = in_rd;
        wr_val   = in_alu_res;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_sel == WB_LOAD) begin
                        complete = mem_rvalid;
                        is_load  = 1'b1;
                        wr_val   = ext_value;
                    end else begin
                        complete = 1'b1;
                        wr_val   = (in_sel == WB_PC4) ? in_pc + XLEN'(4) : in_alu_res;
                    end
                end
            end
            ST_WAIT_LD: begin
                complete = mem_rvalid;
                is_load  = 1'b1;
                wr_en    = ld_wen_q;
                wr_rd    = ld_rd_q;
                wr_val   = ext_value;
            end
            default: ;
        endcase
        err_d    = complete && is_load && ext_err;
        retire_d = complete && !err_d;
        wen_d    = retire_d && wr_en && (wr_rd != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_rd     <= '0;
            rf_rd_v   <= '0;
            retire    <= 1'b0;
            load_err  <= 1'b0;
            instret   <= '0;
            ld_wen_q  <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            rf_wen   <= wen_d;
            retire   <= retire_d;
            load_err <= err_d;
            if (wen_d) begin
                rf_rd   <= wr_rd;
                rf_rd_v <= wr_val;
            end
            if (retire_d) instret <= instret + 1'b1;
            if (start_wait) begin
                ld_wen_q  <= in_wen;
                ld_rd_q   <= in_rd;
                ld_f3_q   <= in_funct3;
                ld_addr_q <= in_addr_lo;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed and randomized self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen;
    logic [4:0]  in_rd;
    logic [1:0]  in_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_res, in_pc;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_v;
    logic        retire, load_err;
    logic [63:0] instret;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] model_instret = 0;

    wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wen     (in_wen),
        .in_rd      (in_rd),
        .in_sel     (in_sel),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .in_alu_res (in_alu_res),
        .in_pc      (in_pc),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_rd_v    (rf_rd_v),
        .retire     (retire),
        .load_err   (load_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load semantics using shifts and masks on the whole word.
    task automatic model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                              output logic [31:0] v, output logic e);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        v = 0;
        e = 0;
        case (f3)
            3'd0: v = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4: v = b;
            3'd1: begin v = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; e = (a % 2) != 0; end
            3'd5: begin v = h; e = (a % 2) != 0; end
            3'd2: begin v = w; e = (a != 0); end
            default: e = 1;
        endcase
    endtask

    task automatic run_txn(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [31:0] rdata, input int delay);
        logic [31:0] ev;
        logic        eerr, is_ld, exp_ret, exp_wen;
        int          d;
        is_ld = (sel == 2'd1);
        d     = is_ld ? delay : 0;
        eerr  = 0;
        if (is_ld)            model_load(f3, a, rdata, ev, eerr);
        else if (sel == 2'd2) ev = pc + 32'd4;
        else                  ev = alu;

        in_valid = 1; in_wen = wen; in_rd = rd; in_sel = sel; in_funct3 = f3;
        in_addr_lo = a; in_alu_res = alu; in_pc = pc; mem_rdata = rdata;
        mem_rvalid = is_ld ? (d == 0) : 1'($urandom_range(0, 1));
        chk("in_ready_accept", in_ready, 1);
        @(posedge clk);
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            chk("in_ready_wait", in_ready, 0);
            chk("rf_wen_wait", rf_wen, 0);
            mem_rvalid = (k == d);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 0; mem_rvalid = 0;

        exp_ret = !(is_ld && eerr);
        exp_wen = exp_ret && wen && (rd != 0);
        if (exp_ret) model_instret = model_instret + 1;
        chk("retire", retire, exp_ret);
        chk("rf_wen", rf_wen, exp_wen);
        chk("load_err", load_err, is_ld && eerr);
        chk("instret", instret, model_instret);
        chk("in_ready_done", in_ready, 1);
        if (exp_wen) begin
            chk("rf_rd", rf_rd, rd);
            chk("rf_rd_v", rf_rd_v, ev);
        end
    endtask

    task automatic idle_cycle(input logic stale);
        mem_rvalid = stale;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 0;
        chk("idle_retire", retire, 0);
        chk("idle_rf_wen", rf_wen, 0);
        chk("idle_load_err", load_err, 0);
        chk("idle_instret", instret, model_instret);
        chk("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_wen = 0; in_rd = 0; in_sel = 0; in_funct3 = 0;
        in_addr_lo = 0; in_alu_res = 0; in_pc = 0; mem_rvalid = 0; mem_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_rd_v", rf_rd_v, 0);
        chk("rst_retire", retire, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;
        @(negedge clk);

        run_txn(1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        run_txn(1, 5'd0, 2'd2, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);
        run_txn(1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);
        run_txn(1, 5'd7, 2'd3, 3'd0, 2'd0, 32'hA5A5_0F0F, 32'h100, 32'h0, 0);
        run_txn(1, 5'd3, 2'd1, 3'd0, 2'd3, 32'h0, 32'h0, 32'h80FF_1122, 0);
        run_txn(1, 5'd3, 2'd1, 3'd4, 2'd3, 32'h0, 32'h0, 32'h80FF_1122, 0);
        run_txn(1, 5'd3, 2'd1, 3'd5, 2'd2, 32'h0, 32'h0, 32'h80FF_1122, 0);
        run_txn(1, 5'd9, 2'd1, 3'd2, 2'd0, 32'h0, 32'h0, 32'hCAFE_BABE, 3);
        run_txn(1, 5'd9, 2'd1, 3'd2, 2'd2, 32'h0, 32'h0, 32'hCAFE_BABE, 0);
        run_txn(1, 5'd9, 2'd1, 3'd3, 2'd0, 32'h0, 32'h0, 32'hCAFE_BABE, 0);
        run_txn(1, 5'd4, 2'd1, 3'd1, 2'd1, 32'h0, 32'h0, 32'h1234_8765, 2);
        idle_cycle(1);

        for (int i = 0; i < 300; i++) begin
            run_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom_range(0, 1)));
        end

        // Reset while a load is pending, then a stale read response.
        in_valid = 1; in_wen = 1; in_rd = 5'd6; in_sel = 2'd1; in_funct3 = 3'd2;
        in_addr_lo = 0; mem_rvalid = 0; mem_rdata = 32'h1111_2222;
        @(posedge clk);
        #2;
        in_valid = 0;
        rst = 1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_instret", instret, 0);
        chk("rst_mid_rf_wen", rf_wen, 0);
        model_instret = 0;
        @(negedge clk);
        rst = 0;
        idle_cycle(1);
        idle_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
